branch_cmp_bht: RTL and testbench

BRANCH_CMP_BHT -- requirements
Module: branch_cmp_bht

---
 rtl/branch_cmp_bht_pkg.sv | 41 ++++
 rtl/branch_cmp_bht_cond.sv | 37 +++
 rtl/branch_cmp_bht.sv | 101 ++++++++++
 tb/tb_branch_cmp_bht.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_cmp_bht_pkg.sv
// Shared encodings for the branch compare / BHT slice: compare modes,
// 2-bit predictor counter states, the reset state of every entry, and
// the saturating counter update rule.
package branch_cmp_bht_pkg;

    // Branch condition selected by cmp_mode
    typedef enum logic [2:0] {
        MODE_BEQ  = 3'b000,
        MODE_BNE  = 3'b001,
        MODE_BLEZ = 3'b010,
        MODE_BGTZ = 3'b011,
        MODE_BLTZ = 3'b100,
        MODE_BGEZ = 3'b101,
        MODE_JUMP = 3'b110,
        MODE_RSVD = 3'b111
    } cmp_mode_e;

    // 2-bit saturating predictor state; the MSB is the prediction
    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } bht_cnt_e;

    // Every entry starts weakly not-taken
    localparam logic [1:0] BHT_RST_VAL = CNT_WNT;

    // Move one step toward the actual outcome, saturating at both ends
    function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken && cur != CNT_ST) begin
            nxt = cur + 2'd1;
        end else if (!taken && cur != CNT_SNT) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cmp_bht_cond.sv
// Branch condition evaluator: pure combinational decode of the compare
// mode against the operands. Zero-compare modes look only at rs_val and
// treat it as a two's complement signed value.
module branch_cond
    import branch_cmp_bht_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             taken
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rs_val[WIDTH-1];
    assign rs_zero = (rs_val == '0);

    // Condition decode; reserved mode never takes
    always_comb begin
        // NOTE: default assignment first so no path leaves taken unassigned (no latch).
        taken = 1'b0;
        case (cmp_mode_e'(mode))
            MODE_BEQ:  taken = (rs_val == rt_val);
            MODE_BNE:  taken = (rs_val != rt_val);
            MODE_BLEZ: taken = rs_neg | rs_zero;
            MODE_BGTZ: taken = ~rs_neg & ~rs_zero;
            MODE_BLTZ: taken = rs_neg;
            MODE_BGEZ: taken = ~rs_neg;
            MODE_JUMP: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cmp_bht.sv
// D-stage branch resolution with a 2-bit bimodal history table.
// The table has two combinational read ports (F-stage lookup and the
// resolving branch) and one write port; reads always return the
// pre-update contents, so a same-index write shows up a cycle later.
module branch_cmp_bht
    import branch_cmp_bht_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int BHT_DEPTH = 16,
    parameter  int CNT_W     = 16,
    localparam int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmp_valid,
    input  logic [2:0]       cmp_mode,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [IDX_W-1:0] br_idx,
    input  logic             flush,
    input  logic [IDX_W-1:0] look_idx,
    output logic             look_taken,
    output logic             jump_judge,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic             res_illegal,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic [1:0] bht [BHT_DEPTH];

    logic cond_taken;
    logic pred;
    logic accept;
    logic illegal;
    logic upd;
    logic mispred;

    branch_cond #(
        .WIDTH (WIDTH)
    ) u_cond (
        .mode   (cmp_mode),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .taken  (cond_taken)
    );

    assign jump_judge = cmp_valid & cond_taken;
    assign look_taken = bht[look_idx][1];
    assign pred       = bht[br_idx][1];
    assign accept     = cmp_valid & ~flush;
    assign illegal    = (cmp_mode == MODE_RSVD);
    assign upd        = accept & ~illegal;
    assign mispred    = (jump_judge != pred);

    // Predictor table: reset every entry, then train on accepted legal branches
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the whole table is reset because predictions must start from a known state.
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= BHT_RST_VAL;
            end
        end else if (upd) begin
            // NOTE: non-blocking so both read ports see the old value this cycle.
            bht[br_idx] <= bht_next(bht[br_idx], jump_judge);
        end
    end

    // Registered resolution result, one cycle after an accepted branch
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_mispredict <= 1'b0;
            res_illegal    <= 1'b0;
        end else begin
            res_valid      <= accept;
            res_taken      <= accept & jump_judge;
            res_mispredict <= accept & mispred;
            res_illegal    <= accept & illegal;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (accept) begin
            if (branch_cnt != '1) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispred && mispred_cnt != '1) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_cmp_bht.sv
// Directed bench for branch_cmp_bht with narrow (4-bit) counters so that
// saturation is reached quickly. Inputs change 1 time unit after the
// rising edge; outputs are sampled before the next edge.
module tb_branch_cmp_bht;
    import branch_cmp_bht_pkg::*;

    localparam int WIDTH     = 32;
    localparam int BHT_DEPTH = 16;
    localparam int CNT_W     = 4;
    localparam int IDX_W     = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmp_valid;
    logic [2:0]       cmp_mode;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [IDX_W-1:0] br_idx;
    logic             flush;
    logic [IDX_W-1:0] look_idx;
    logic             look_taken;
    logic             jump_judge;
    logic             res_valid;
    logic             res_taken;
    logic             res_mispredict;
    logic             res_illegal;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_cmp_bht #(
        .WIDTH     (WIDTH),
        .BHT_DEPTH (BHT_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmp_valid      (cmp_valid),
        .cmp_mode       (cmp_mode),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .br_idx         (br_idx),
        .flush          (flush),
        .look_idx       (look_idx),
        .look_taken     (look_taken),
        .jump_judge     (jump_judge),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict),
        .res_illegal    (res_illegal),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [3:0] idx, input logic fl);
        cmp_valid = v;
        cmp_mode  = m;
        rs_val    = rs;
        rt_val    = rt;
        br_idx    = idx;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic v, input logic t,
                             input logic mp, input logic il);
        check({tag, ".res_valid"},      res_valid,      v);
        check({tag, ".res_taken"},      res_taken,      t);
        check({tag, ".res_mispredict"}, res_mispredict, mp);
        check({tag, ".res_illegal"},    res_illegal,    il);
    endtask

    task automatic check_cnt(input string tag, input logic [3:0] b, input logic [3:0] m);
        check({tag, ".branch_cnt"},  branch_cnt,  b);
        check({tag, ".mispred_cnt"}, mispred_cnt, m);
    endtask

    task automatic check_bht_all(input string tag, input logic [1:0] exp);
        for (int i = 0; i < BHT_DEPTH; i++) begin
            check($sformatf("%s.bht%0d", tag, i), dut.bht[i], exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [2:0]  m;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        exp;
    } jj_vec_t;

    jj_vec_t jj_vecs[12];

    initial begin
        // Condition patterns checked with flush=1 so no state changes
        jj_vecs[0]  = '{1'b1, MODE_BNE,  32'h1,        32'h2, 1'b1};
        jj_vecs[1]  = '{1'b1, MODE_BNE,  32'h7,        32'h7, 1'b0};
        jj_vecs[2]  = '{1'b1, MODE_BEQ,  32'h1,        32'h2, 1'b0};
        jj_vecs[3]  = '{1'b1, MODE_BLEZ, 32'hFFFFFFFF, 32'h0, 1'b1};
        jj_vecs[4]  = '{1'b1, MODE_BLEZ, 32'h1,        32'h0, 1'b0};
        jj_vecs[5]  = '{1'b1, MODE_BGTZ, 32'h7FFFFFFF, 32'h0, 1'b1};
        jj_vecs[6]  = '{1'b1, MODE_BLTZ, 32'h0,        32'h0, 1'b0};
        jj_vecs[7]  = '{1'b1, MODE_BGEZ, 32'h80000000, 32'h0, 1'b0};
        jj_vecs[8]  = '{1'b1, MODE_JUMP, 32'h0,        32'h0, 1'b1};
        jj_vecs[9]  = '{1'b1, MODE_RSVD, 32'h5,        32'h5, 1'b0};
        jj_vecs[10] = '{1'b0, MODE_JUMP, 32'h0,        32'h0, 1'b0};
        jj_vecs[11] = '{1'b1, MODE_BEQ,  32'h3,        32'h3, 1'b1};

        // Reset with a branch presented: it must be discarded
        reset    = 1'b0;
        look_idx = 4'd0;
        drive(1'b1, MODE_BEQ, 32'h5, 32'h5, 4'd5, 1'b0);
        tick();
        tick();
        check_res("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_cnt("rst", 4'd0, 4'd0);
        check_bht_all("rst", 2'b01);
        check("rst.look_taken", look_taken, 1'b0);

        reset = 1'b1;
        drive(1'b0, MODE_BEQ, 32'h0, 32'h0, 4'd0, 1'b0);
        tick();
        check_res("release", 1'b0, 1'b0, 1'b0, 1'b0);

        // BEQ taken at idx 3, predicted not-taken
        drive(1'b1, MODE_BEQ, 32'h5, 32'h5, 4'd3, 1'b0);
        #1 check("beq.jump_judge", jump_judge, 1'b1);
        tick();
        check_res("beq", 1'b1, 1'b1, 1'b1, 1'b0);
        check("beq.bht3", dut.bht[3], 2'b10);
        check_cnt("beq", 4'd1, 4'd1);

        // Signed zero compares: BLTZ, BGEZ, BGTZ
        drive(1'b1, MODE_BLTZ, 32'h80000000, 32'h0, 4'd0, 1'b0);
        #1 check("bltz.jump_judge", jump_judge, 1'b1);
        tick();
        drive(1'b1, MODE_BGEZ, 32'h0, 32'h0, 4'd1, 1'b0);
        #1 check("bgez.jump_judge", jump_judge, 1'b1);
        tick();
        drive(1'b1, MODE_BGTZ, 32'h0, 32'h0, 4'd4, 1'b0);
        #1 check("bgtz.jump_judge", jump_judge, 1'b0);
        tick();
        check_res("bgtz", 1'b1, 1'b0, 1'b0, 1'b0);
        check("bgtz.bht4", dut.bht[4], 2'b00);
        check_cnt("zero_cmp", 4'd4, 4'd3);

        // Combinational condition table, all flushed
        for (int i = 0; i < 12; i++) begin
            drive(jj_vecs[i].v, jj_vecs[i].m, jj_vecs[i].rs, jj_vecs[i].rt, 4'd9, 1'b1);
            #1 check($sformatf("jj_vec%0d", i), jump_judge, jj_vecs[i].exp);
        end
        tick();
        check_res("flush", 1'b0, 1'b0, 1'b0, 1'b0);
        check("flush.bht9", dut.bht[9], 2'b01);
        check_cnt("flush", 4'd4, 4'd3);

        // Saturation at idx 7: four taken (one via JUMP), then not-taken
        drive(1'b1, MODE_BEQ, 32'h1, 32'h1, 4'd7, 1'b0);
        tick();
        check("sat1.bht7", dut.bht[7], 2'b10);
        check("sat1.mispredict", res_mispredict, 1'b1);
        drive(1'b1, MODE_JUMP, 32'h0, 32'h0, 4'd7, 1'b0);
        tick();
        check("sat2.bht7", dut.bht[7], 2'b11);
        check("sat2.mispredict", res_mispredict, 1'b0);
        drive(1'b1, MODE_BEQ, 32'h2, 32'h2, 4'd7, 1'b0);
        tick();
        check("sat3.bht7", dut.bht[7], 2'b11);
        tick();
        check("sat4.bht7", dut.bht[7], 2'b11);
        check_cnt("sat4", 4'd8, 4'd4);
        drive(1'b1, MODE_BNE, 32'h2, 32'h2, 4'd7, 1'b0);
        tick();
        check("sat5.bht7", dut.bht[7], 2'b10);
        check_res("sat5", 1'b1, 1'b0, 1'b1, 1'b0);
        check_cnt("sat5", 4'd9, 4'd5);

        // Same-index lookup and update at idx 2
        look_idx = 4'd2;
        drive(1'b1, MODE_BEQ, 32'h4, 32'h4, 4'd2, 1'b0);
        #1 check("bypass.look_old", look_taken, 1'b0);
        tick();
        check("bypass.look_new", look_taken, 1'b1);
        check("bypass.bht2", dut.bht[2], 2'b10);

        // Reserved mode: illegal, mispredicts against taken-predicted entry, no training
        drive(1'b1, MODE_RSVD, 32'h4, 32'h4, 4'd2, 1'b0);
        #1 check("rsvd.jump_judge", jump_judge, 1'b0);
        tick();
        check_res("rsvd", 1'b1, 1'b0, 1'b1, 1'b1);
        check("rsvd.bht2", dut.bht[2], 2'b10);
        check_cnt("rsvd", 4'd11, 4'd7);

        // Twenty mispredicting branches alternating at idx 10
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) drive(1'b1, MODE_BEQ, 32'h1, 32'h1, 4'd10, 1'b0);
            else            drive(1'b1, MODE_BEQ, 32'h1, 32'h2, 4'd10, 1'b0);
            tick();
            check($sformatf("mp%0d.mispredict", i), res_mispredict, 1'b1);
            if (i == 3) check_cnt("mp3", 4'd15, 4'd11);
        end
        check_cnt("mp_sat", 4'hF, 4'hF);

        // Reset mid-stream with a branch pending
        reset = 1'b0;
        drive(1'b1, MODE_BEQ, 32'h1, 32'h1, 4'd7, 1'b0);
        tick();
        check_res("rst2", 1'b0, 1'b0, 1'b0, 1'b0);
        check_cnt("rst2", 4'd0, 4'd0);
        check_bht_all("rst2", 2'b01);

        reset = 1'b1;
        drive(1'b0, MODE_BEQ, 32'h0, 32'h0, 4'd0, 1'b0);
        tick();
        check_res("rst2_release", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, MODE_BEQ, 32'h9, 32'h9, 4'd3, 1'b0);
        tick();
        check_res("post_rst", 1'b1, 1'b1, 1'b1, 1'b0);
        check_cnt("post_rst", 4'd1, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
